// File: rtl/ysyx_22041207_fetch_unit.sv
// ysyx_22041207_fetch_unit: IF stage with a valid/ready imem port, a {pc, inst} fetch queue and an EX redirect input.
// Define YSYX_22041207_IFU_MISALIGN_CHK_EN to turn misaligned redirect targets into a single fault entry.
module ysyx_22041207_fetch_unit #(
   parameter int          XLEN     = 64,
   parameter logic [63:0] RESET_PC = 64'h8000_0000,
   parameter int          FQ_DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [63:0]     imem_rsp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic [31:0]     inst_o,
   output logic [XLEN-1:0] pc_o,
   output logic            fault_o
);
   localparam int PW = $clog2(FQ_DEPTH);
   localparam int CW = PW + 1;
   typedef enum logic [1:0] {IDLE, REQ, WAIT, KILL} state_t;
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [31:0]     inst;
      logic            fault;
   } ent_t;
   state_t          state_q, state_d;
   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, addr_q, addr_d, tgt;
   logic [PW-1:0]   wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            halt_q, halt_d, mis, push, pop, fire, can_go;
   ent_t            fq_q [FQ_DEPTH];
   ent_t            fq_d [FQ_DEPTH];
   ent_t            head;
`ifdef YSYX_22041207_IFU_MISALIGN_CHK_EN
   assign mis = |redirect_pc[1:0];
   assign tgt = redirect_pc;
`else
   assign mis = 1'b0;
   assign tgt = redirect_pc & ~XLEN'(3);
`endif
   assign head           = fq_q[rd_q];
   assign inst_valid     = cnt_q != '0;
   assign inst_o         = inst_valid ? head.inst : '0;
   assign pc_o           = inst_valid ? head.pc : '0;
   assign fault_o        = inst_valid & head.fault;
   // a redirect or reset withdraws a request in the same cycle
   assign imem_req_valid = state_q == REQ && !redirect_valid && !rst;
   assign imem_req_addr  = fetch_pc_q;
   assign fire           = imem_req_valid && imem_req_ready;
   assign push           = state_q == WAIT && imem_rsp_valid && !redirect_valid;
   assign pop            = inst_valid && inst_ready && !redirect_valid;
   always_comb begin
      fq_d  = fq_q;
      wr_d  = wr_q + PW'(push);
      rd_d  = rd_q + PW'(pop);
      cnt_d = cnt_q + CW'(push) - CW'(pop);
      if (push) fq_d[wr_q] = {addr_q, addr_q[2] ? imem_rsp_data[63:32] : imem_rsp_data[31:0], 1'b0};
      if (redirect_valid) begin
         rd_d  = '0;
         wr_d  = PW'(mis);
         cnt_d = CW'(mis);
         if (mis) fq_d[0] = {tgt, 32'h0, 1'b1};
      end
   end
   always_comb begin
      halt_d     = redirect_valid ? mis : halt_q;
      can_go     = !halt_d && cnt_d < CW'(FQ_DEPTH);
      fetch_pc_d = redirect_valid ? tgt : fire ? fetch_pc_q + XLEN'(4) : fetch_pc_q;
      addr_d     = fire ? fetch_pc_q : addr_q;
      state_d    = state_q;
      case (state_q)
         IDLE:    state_d = can_go ? REQ : IDLE;
         REQ:     state_d = fire ? WAIT : REQ;
         WAIT:    state_d = imem_rsp_valid ? (can_go ? REQ : IDLE) : WAIT;
         KILL:    state_d = imem_rsp_valid ? IDLE : KILL;
         default: state_d = IDLE;
      endcase
      // a response in the redirect cycle retires the outstanding request, so no kill is needed
      if (redirect_valid) state_d = (state_q inside {WAIT, KILL}) && !imem_rsp_valid ? KILL : can_go ? REQ : IDLE;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         fetch_pc_q <= RESET_PC[XLEN-1:0];
         addr_q     <= '0;
         wr_q       <= '0;
         rd_q       <= '0;
         cnt_q      <= '0;
         halt_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         addr_q     <= addr_d;
         wr_q       <= wr_d;
         rd_q       <= rd_d;
         cnt_q      <= cnt_d;
         halt_q     <= halt_d;
      end
      fq_q <= fq_d;
   end
endmodule

// File: tb/tb_ysyx_22041207_fetch_unit.sv
// tb_ysyx_22041207_fetch_unit: randomized bench with an in-bench memory and a sequential-PC reference model.
module tb_ysyx_22041207_fetch_unit;
   localparam logic [63:0] RST_PC = 64'h8000_0000;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic imem_req_valid, imem_req_ready = 1'b0;
   logic [63:0] imem_req_addr;
   logic imem_rsp_valid = 1'b0;
   logic [63:0] imem_rsp_data = '0;
   logic redirect_valid = 1'b0;
   logic [63:0] redirect_pc = '0;
   logic inst_valid, inst_ready = 1'b0, fault_o;
   logic [31:0] inst_o;
   logic [63:0] pc_o;
   always #5 clk = ~clk;
   ysyx_22041207_fetch_unit dut (
      .clk(clk), .rst(rst),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_o(inst_o), .pc_o(pc_o), .fault_o(fault_o)
   );
   int n_chk = 0, n_fail = 0;
   int p_ready = 100, p_iready = 100, lat_min = 0, lat_max = 0, redir_done = 0;
   bit rst_cmd = 1, const_data = 0, do_redir = 0, redir_on_wait = 0, redir_on_rsp = 0, rnd_redir = 0;
   logic [63:0] redir_tgt = '0;
   bit pend = 0;
   int lat = 0;
   logic [63:0] pend_addr = '0;
   logic [63:0] exp_pc = RST_PC, exp_req = RST_PC, fault_pc = '0, hold_p = '0;
   logic [31:0] hold_i = '0;
   bit halted = 0, fault_pend = 0, hold_v = 0, flush_chk = 0, flush_exp_v = 0;
   logic [63:0] acc_q[$];
   logic [63:0] pop_pc[$];
   logic [63:0] pop_in[$];
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   function automatic logic [31:0] hw(input logic [63:0] a);
      return a[31:0] * 32'h9E37_79B1 + 32'h1234_5678;
   endfunction
   function automatic logic [63:0] dw(input logic [63:0] a);
      return const_data ? 64'hAAAA_AAAA_BBBB_BBBB : {hw({a[63:3], 3'b100}), hw({a[63:3], 3'b000})};
   endfunction
   function automatic logic [31:0] exp_word(input logic [63:0] p);
      return const_data ? (p[2] ? 32'hAAAA_AAAA : 32'hBBBB_BBBB) : hw(p);
   endfunction
   function automatic logic [63:0] qat(input logic [63:0] q[$], input int i);
      return (i < q.size()) ? q[i] : 64'hDEAD_DEAD_DEAD_DEAD;
   endfunction
   task automatic cycle();
      bit rv, mis;
      logic [63:0] tgt;
      @(negedge clk);
      rst = rst_cmd;
      imem_rsp_valid = 1'b0;
      imem_rsp_data = {$urandom, $urandom};
      if (pend) begin
         if (lat == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data = dw(pend_addr);
            pend = 0;
         end else lat--;
      end
      imem_req_ready = $urandom_range(99) < p_ready;
      inst_ready = $urandom_range(99) < p_iready;
      rv = do_redir;
      tgt = redir_tgt;
      if (redir_on_wait && pend) rv = 1;
      if (redir_on_rsp && imem_rsp_valid && inst_valid) begin
         rv = 1;
         inst_ready = 1'b1;
      end
      if (rnd_redir && $urandom_range(99) < 3) begin
         rv = 1;
         tgt = RST_PC + 64'($urandom_range(1023));
`ifdef YSYX_22041207_IFU_MISALIGN_CHK_EN
         tgt[1:0] = 2'b00;
`endif
      end
      if (rv && !rnd_redir) begin
         do_redir = 0;
         redir_on_wait = 0;
         redir_on_rsp = 0;
         redir_done++;
      end
      redirect_valid = rv;
      redirect_pc = rv ? tgt : {$urandom, $urandom};
      #1;
      if (hold_v) begin
         chk("hold_valid", inst_valid, 1);
         chk("hold_pc", pc_o, hold_p);
         chk("hold_inst", inst_o, hold_i);
      end
      if (flush_chk) chk("flush_valid", inst_valid, flush_exp_v);
      hold_v = 0;
      flush_chk = 0;
      if (rst) begin
         exp_pc = RST_PC;
         exp_req = RST_PC;
         halted = 0;
         fault_pend = 0;
         flush_chk = 1;
         flush_exp_v = 0;
         return;
      end
      if (pend || rv || halted) chk("req_blocked", imem_req_valid, 0);
      if (imem_req_valid && imem_req_ready) begin
         chk("req_addr", imem_req_addr, exp_req);
         exp_req += 4;
         acc_q.push_back(imem_req_addr);
         pend = 1;
         lat = $urandom_range(lat_max, lat_min);
         pend_addr = imem_req_addr;
      end
      if (inst_valid && !rv) begin
         if (inst_ready) begin
            if (fault_pend) begin
               chk("fault_pc", pc_o, fault_pc);
               chk("fault_inst", inst_o, 0);
               chk("fault_flag", fault_o, 1);
               fault_pend = 0;
            end else begin
               chk("pop_pc", pc_o, exp_pc);
               chk("pop_inst", inst_o, exp_word(exp_pc));
               chk("pop_fault", fault_o, 0);
               exp_pc += 4;
            end
            pop_pc.push_back(pc_o);
            pop_in.push_back(64'(inst_o));
         end else begin
            hold_v = 1;
            hold_p = pc_o;
            hold_i = inst_o;
         end
      end
      if (rv) begin
`ifdef YSYX_22041207_IFU_MISALIGN_CHK_EN
         mis = tgt[1:0] != 2'b00;
`else
         mis = 0;
`endif
         flush_chk = 1;
         flush_exp_v = mis;
         fault_pend = mis;
         fault_pc = tgt;
         halted = mis;
         exp_pc = {tgt[63:2], 2'b00};
         exp_req = exp_pc;
      end
   endtask
   task automatic clear_logs();
      acc_q.delete();
      pop_pc.delete();
      pop_in.delete();
   endtask
   task automatic wait_redir(input string name);
      int d0 = redir_done;
      for (int i = 0; i < 100 && redir_done == d0; i++) cycle();
      chk(name, 64'(redir_done), 64'(d0 + 1));
   endtask
   initial begin
      int a0, p0;
      const_data = 1;
      cycle();
      cycle();
      chk("rst_req_valid", imem_req_valid, 0);
      chk("rst_inst_valid", inst_valid, 0);
      chk("rst_inst_o", inst_o, 0);
      chk("rst_pc_o", pc_o, 0);
      chk("rst_fault_o", fault_o, 0);
      rst_cmd = 0;
      cycle();
      chk("idle_after_rst", imem_req_valid, 0);
      repeat (12) cycle();
      chk("t1_acc0", qat(acc_q, 0), 64'h8000_0000);
      chk("t1_acc1", qat(acc_q, 1), 64'h8000_0004);
      chk("t1_acc2", qat(acc_q, 2), 64'h8000_0008);
      chk("t2_pc0", qat(pop_pc, 0), 64'h8000_0000);
      chk("t2_inst0", qat(pop_in, 0), 64'hBBBB_BBBB);
      chk("t2_pc1", qat(pop_pc, 1), 64'h8000_0004);
      chk("t2_inst1", qat(pop_in, 1), 64'hAAAA_AAAA);
      const_data = 0;
      rst_cmd = 1;
      cycle();
      cycle();
      rst_cmd = 0;
      clear_logs();
      p_iready = 0;
      repeat (20) cycle();
      chk("t3_fill_reqs", 64'(acc_q.size()), 4);
      chk("t3_req_idle", imem_req_valid, 0);
      chk("t3_full_valid", inst_valid, 1);
      p_iready = 100;
      repeat (10) cycle();
      for (int i = 0; i < 4; i++) chk("t3_pop_order", qat(pop_pc, i), RST_PC + 64'(4 * i));
      chk("t3_resume", qat(acc_q, 4), 64'h8000_0010);
      lat_max = 2;
      clear_logs();
      redir_tgt = 64'h8000_0100;
      redir_on_wait = 1;
      wait_redir("t4_redirect_fired");
      a0 = acc_q.size();
      p0 = pop_pc.size();
      repeat (20) cycle();
      chk("t4_req_addr", qat(acc_q, a0), 64'h8000_0100);
      chk("t4_first_pop", qat(pop_pc, p0), 64'h8000_0100);
      p_iready = 50;
      redir_tgt = 64'h8000_0200;
      redir_on_rsp = 1;
      wait_redir("t5_redirect_fired");
      p0 = pop_pc.size();
      p_iready = 100;
      repeat (20) cycle();
      chk("t5_first_pop", qat(pop_pc, p0), 64'h8000_0200);
      lat_min = 1;
      lat_max = 1;
      a0 = acc_q.size();
      for (int i = 0; i < 50 && acc_q.size() == a0; i++) cycle();
      rst_cmd = 1;
      cycle();
      rst_cmd = 0;
      a0 = acc_q.size();
      p0 = pop_pc.size();
      repeat (12) cycle();
      chk("rst_mid_req", qat(acc_q, a0), RST_PC);
      chk("rst_mid_pop", qat(pop_pc, p0), RST_PC);
`ifdef YSYX_22041207_IFU_MISALIGN_CHK_EN
      redir_tgt = 64'h8000_0102;
      do_redir = 1;
      p_iready = 0;
      wait_redir("t6_redirect_fired");
      a0 = acc_q.size();
      cycle();
      chk("t6_valid", inst_valid, 1);
      chk("t6_fault", fault_o, 1);
      chk("t6_pc", pc_o, 64'h8000_0102);
      chk("t6_inst", inst_o, 0);
      p_iready = 100;
      repeat (20) cycle();
      chk("t6_no_req", 64'(acc_q.size()), 64'(a0));
      chk("t6_drained", inst_valid, 0);
`endif
      lat_min = 0;
      lat_max = 3;
      p_ready = 70;
      p_iready = 60;
      rnd_redir = 1;
      clear_logs();
      repeat (3000) cycle();
      chk("rand_progress", 64'(pop_pc.size() > 300), 1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
